// File: rtl/dec_response_checker.sv
// Response checker for the decoder test environment.
// Predicts each instruction's decode class and scores the decoder flags.
module dec_response_checker #(
    parameter int DEC_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_rdata_i,
    input  logic [9:0]       dec_flags_i,
    input  logic             clear_i,
    input  logic [3:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] txn_count_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic             err_sticky_o,
    output logic [31:0]      first_err_instr_o,
    output logic [3:0]       first_err_class_o
);

    localparam logic [3:0] CLS_ILL  = 4'd0;
    localparam logic [3:0] CLS_ECAL = 4'd1;
    localparam logic [3:0] CLS_EBRK = 4'd2;
    localparam logic [3:0] CLS_WFI  = 4'd3;
    localparam logic [3:0] CLS_MRET = 4'd4;
    localparam logic [3:0] CLS_DRET = 4'd5;
    localparam logic [3:0] CLS_JUMP = 4'd6;
    localparam logic [3:0] CLS_BR   = 4'd7;
    localparam logic [3:0] CLS_LD   = 4'd8;
    localparam logic [3:0] CLS_ST   = 4'd9;
    localparam logic [3:0] CLS_NONE = 4'd10;
    localparam logic [3:0] CLS_SPUR = 4'd15;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] exp_cls;

    assign opc = instr_rdata_i[6:0];
    assign f3  = instr_rdata_i[14:12];
    assign f7  = instr_rdata_i[31:25];

    always_comb begin
        exp_cls = CLS_ILL;
        case (opc)
            7'h73: begin
                if (instr_rdata_i == 32'h0000_0073)      exp_cls = CLS_ECAL;
                else if (instr_rdata_i == 32'h0010_0073) exp_cls = CLS_EBRK;
                else if (instr_rdata_i == 32'h1050_0073) exp_cls = CLS_WFI;
                else if (instr_rdata_i == 32'h3020_0073) exp_cls = CLS_MRET;
                else if (instr_rdata_i == 32'h7B20_0073) exp_cls = CLS_DRET;
                else if (f3 == 3'd0 || f3 == 3'd4)       exp_cls = CLS_ILL;
                else                                     exp_cls = CLS_NONE;
            end
            7'h6F: exp_cls = CLS_JUMP;
            7'h67: exp_cls = (f3 == 3'd0) ? CLS_JUMP : CLS_ILL;
            7'h63: exp_cls = (f3 == 3'd2 || f3 == 3'd3) ? CLS_ILL : CLS_BR;
            7'h03: exp_cls = (f3 == 3'd3 || f3 >= 3'd6) ? CLS_ILL : CLS_LD;
            7'h23: exp_cls = (f3 > 3'd2) ? CLS_ILL : CLS_ST;
            7'h37, 7'h17: exp_cls = CLS_NONE;
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00)
                    exp_cls = CLS_ILL;
                else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
                    exp_cls = CLS_ILL;
                else
                    exp_cls = CLS_NONE;
            end
            7'h33: begin
                if (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01)
                    exp_cls = CLS_NONE;
                else
                    exp_cls = CLS_ILL;
            end
            default: exp_cls = CLS_ILL;
        endcase
    end

    logic        pipe_v [DEC_LATENCY];
    logic [3:0]  pipe_c [DEC_LATENCY];
    logic [31:0] pipe_i [DEC_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEC_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_c[i] <= 4'd0;
                pipe_i[i] <= 32'd0;
            end
        end else begin
            pipe_v[0] <= instr_valid_i;
            pipe_c[0] <= exp_cls;
            pipe_i[0] <= instr_rdata_i;
            for (int i = 1; i < DEC_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_c[i] <= pipe_c[i-1];
                pipe_i[i] <= pipe_i[i-1];
            end
        end
    end

    logic        last_v;
    logic [3:0]  last_c;
    logic [9:0]  exp_flags;
    logic        cmp_err;

    assign last_v    = pipe_v[DEC_LATENCY-1];
    assign last_c    = pipe_c[DEC_LATENCY-1];
    // The none class shifts the bit out of range, giving all-zero flags.
    assign exp_flags = 10'b1 << last_c;
    assign cmp_err   = last_v ? (dec_flags_i != exp_flags) : (dec_flags_i != 10'd0);

    logic        res_v;
    logic        res_err;
    logic [3:0]  res_cls;
    logic [31:0] res_instr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_v     <= 1'b0;
            res_err   <= 1'b0;
            res_cls   <= 4'd0;
            res_instr <= 32'd0;
        end else begin
            res_v     <= last_v & ~clear_i;
            res_err   <= cmp_err & ~clear_i;
            res_cls   <= last_v ? last_c : CLS_SPUR;
            res_instr <= last_v ? pipe_i[DEC_LATENCY-1] : 32'd0;
        end
    end

    logic [CNT_W-1:0] cls_cnt [11];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 11; k++) cls_cnt[k] <= '0;
            txn_count_o       <= '0;
            mismatch_o        <= 1'b0;
            err_count_o       <= '0;
            err_sticky_o      <= 1'b0;
            first_err_instr_o <= 32'd0;
            first_err_class_o <= 4'd0;
        end else if (clear_i) begin
            for (int k = 0; k < 11; k++) cls_cnt[k] <= '0;
            txn_count_o       <= '0;
            mismatch_o        <= 1'b0;
            err_count_o       <= '0;
            err_sticky_o      <= 1'b0;
            first_err_instr_o <= 32'd0;
            first_err_class_o <= 4'd0;
        end else begin
            mismatch_o <= res_err;
            if (res_v) begin
                txn_count_o <= sat_inc(txn_count_o);
                for (int k = 0; k < 11; k++)
                    if (res_cls == 4'(k)) cls_cnt[k] <= sat_inc(cls_cnt[k]);
            end
            if (res_err) begin
                err_count_o <= sat_inc(err_count_o);
                if (!err_sticky_o) begin
                    err_sticky_o      <= 1'b1;
                    first_err_instr_o <= res_instr;
                    first_err_class_o <= res_cls;
                end
            end
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < 11; k++)
            if (cnt_sel_i == 4'(k)) cnt_o = cls_cnt[k];
    end

endmodule

// File: tb/tb_dec_response_checker.sv
// Directed bench for dec_response_checker at latencies 1 and 3 and a 4-bit counter build.
module tb_dec_response_checker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic [31:0] instr_rdata_i;
    logic [9:0]  dec_flags_i;
    logic        clear_i;
    logic [3:0]  cnt_sel_i;

    logic [15:0] cnt1, txn1, errc1;
    logic        mis1, stk1;
    logic [31:0] fei1;
    logic [3:0]  fec1;

    logic [15:0] cnt3, txn3, errc3;
    logic        mis3, stk3;
    logic [31:0] fei3;
    logic [3:0]  fec3;

    logic [3:0]  cnt4, txn4, errc4;
    logic        mis4, stk4;
    logic [31:0] fei4;
    logic [3:0]  fec4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    dec_response_checker #(.DEC_LATENCY(1), .CNT_W(16)) u1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i),
        .instr_rdata_i(instr_rdata_i), .dec_flags_i(dec_flags_i),
        .clear_i(clear_i), .cnt_sel_i(cnt_sel_i), .cnt_o(cnt1),
        .txn_count_o(txn1), .mismatch_o(mis1), .err_count_o(errc1),
        .err_sticky_o(stk1), .first_err_instr_o(fei1), .first_err_class_o(fec1)
    );

    dec_response_checker #(.DEC_LATENCY(3), .CNT_W(16)) u3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i),
        .instr_rdata_i(instr_rdata_i), .dec_flags_i(dec_flags_i),
        .clear_i(clear_i), .cnt_sel_i(cnt_sel_i), .cnt_o(cnt3),
        .txn_count_o(txn3), .mismatch_o(mis3), .err_count_o(errc3),
        .err_sticky_o(stk3), .first_err_instr_o(fei3), .first_err_class_o(fec3)
    );

    dec_response_checker #(.DEC_LATENCY(1), .CNT_W(4)) u4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i),
        .instr_rdata_i(instr_rdata_i), .dec_flags_i(dec_flags_i),
        .clear_i(clear_i), .cnt_sel_i(cnt_sel_i), .cnt_o(cnt4),
        .txn_count_o(txn4), .mismatch_o(mis4), .err_count_o(errc4),
        .err_sticky_o(stk4), .first_err_instr_o(fei4), .first_err_class_o(fec4)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        instr_valid_i = 1'b0;
        instr_rdata_i = 32'd0;
        dec_flags_i   = 10'd0;
        clear_i       = 1'b0;
        rst_ni        = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // Accept ins at edge N, present fl so it is sampled at edge N+k,
    // return just after edge N+k+1.
    task automatic run_one(input logic [31:0] ins, input logic [9:0] fl, input int k);
        instr_rdata_i = ins;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        repeat (k - 1) tick();
        dec_flags_i = fl;
        tick();
        dec_flags_i = 10'd0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        cnt_sel_i = 4'd10;
        n_cmp++;
        if ({cnt1, txn1, errc1, mis1, stk1, fei1, fec1} !== 86'd0) begin
            n_bad++;
            $display("FAIL reset_state u1 got cnt=%0d txn=%0d err=%0d mis=%0b stk=%0b fei=%h fec=%0d want all 0",
                     cnt1, txn1, errc1, mis1, stk1, fei1, fec1);
        end
        // Reset mid-flight on the latency-3 instance discards the instruction.
        instr_rdata_i = 32'h0FFF_FFFF;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (txn3 !== 16'd0 || errc3 !== 16'd0 || stk3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midstream txn=%0d err=%0d stk=%0b want 0 0 0", txn3, errc3, stk3);
        end
    endtask

    task automatic test_match_and_errors();
        do_reset();
        run_one(32'h1050_0073, 10'h008, 1);
        cnt_sel_i = 4'd3;
        #1;
        n_cmp++;
        if (mis1 !== 1'b0 || cnt1 !== 16'd1 || txn1 !== 16'd1) begin
            n_bad++;
            $display("FAIL wfi_match mis=%0b cnt=%0d txn=%0d want 0 1 1", mis1, cnt1, txn1);
        end
        run_one(32'h0FFF_FFFF, 10'h000, 1);
        n_cmp++;
        if (mis1 !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_pulse mis=%0b want 1", mis1);
        end
        n_cmp++;
        if (stk1 !== 1'b1 || fei1 !== 32'h0FFF_FFFF || fec1 !== 4'd0 || errc1 !== 16'd1) begin
            n_bad++;
            $display("FAIL illegal_capture stk=%0b fei=%h fec=%0d err=%0d want 1 0fffffff 0 1",
                     stk1, fei1, fec1, errc1);
        end
        tick();
        n_cmp++;
        if (mis1 !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width mis=%0b want 0", mis1);
        end
        run_one(32'h0000_2063, 10'h001, 1);
        n_cmp++;
        if (mis1 !== 1'b0 || errc1 !== 16'd1) begin
            n_bad++;
            $display("FAIL branch_f3_2_illegal mis=%0b err=%0d want 0 1", mis1, errc1);
        end
        run_one(32'h0001_8023, 10'h000, 1);
        cnt_sel_i = 4'd0;
        #1;
        n_cmp++;
        if (mis1 !== 1'b1 || errc1 !== 16'd2 || fei1 !== 32'h0FFF_FFFF || fec1 !== 4'd0) begin
            n_bad++;
            $display("FAIL first_err_kept mis=%0b err=%0d fei=%h fec=%0d want 1 2 0fffffff 0",
                     mis1, errc1, fei1, fec1);
        end
        n_cmp++;
        if (cnt1 !== 16'd2 || txn1 !== 16'd4) begin
            n_bad++;
            $display("FAIL class_counts illegal=%0d txn=%0d want 2 4", cnt1, txn1);
        end
        cnt_sel_i = 4'd9;
        #1;
        n_cmp++;
        if (cnt1 !== 16'd1) begin
            n_bad++;
            $display("FAIL store_count got %0d want 1", cnt1);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        dec_flags_i = 10'h200;
        tick();
        dec_flags_i = 10'd0;
        tick();
        n_cmp++;
        if (mis1 !== 1'b1 || fec1 !== 4'd15 || fei1 !== 32'd0 || txn1 !== 16'd0 || errc1 !== 16'd1) begin
            n_bad++;
            $display("FAIL spurious mis=%0b fec=%0d fei=%h txn=%0d err=%0d want 1 15 0 0 1",
                     mis1, fec1, fei1, txn1, errc1);
        end
        run_one(32'h0000_006F, 10'h0C0, 1);
        n_cmp++;
        if (mis1 !== 1'b1 || errc1 !== 16'd2 || txn1 !== 16'd1) begin
            n_bad++;
            $display("FAIL multi_flag mis=%0b err=%0d txn=%0d want 1 2 1", mis1, errc1, txn1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cnt_sel_i = 4'd10;
        instr_rdata_i = 32'hE000_C113;
        instr_valid_i = 1'b1;
        repeat (20) tick();
        instr_valid_i = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (cnt4 !== 4'd15 || txn4 !== 4'd15) begin
            n_bad++;
            $display("FAIL saturate cnt=%0d txn=%0d want 15 15", cnt4, txn4);
        end
        n_cmp++;
        if (errc4 !== 4'd0 || stk4 !== 1'b0) begin
            n_bad++;
            $display("FAIL saturate_noerr err=%0d stk=%0b want 0 0", errc4, stk4);
        end
        n_cmp++;
        if (cnt1 !== 16'd20 || txn1 !== 16'd20) begin
            n_bad++;
            $display("FAIL b2b_wide cnt=%0d txn=%0d want 20 20", cnt1, txn1);
        end
    endtask

    task automatic test_clear();
        do_reset();
        run_one(32'h0FFF_FFFF, 10'h000, 1);
        instr_rdata_i = 32'h0FFF_FFFF;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        n_cmp++;
        if (mis1 !== 1'b0 || errc1 !== 16'd0 || stk1 !== 1'b0 || txn1 !== 16'd0 || fei1 !== 32'd0) begin
            n_bad++;
            $display("FAIL clear_discard mis=%0b err=%0d stk=%0b txn=%0d fei=%h want 0 0 0 0 0",
                     mis1, errc1, stk1, txn1, fei1);
        end
    endtask

    task automatic test_latency3();
        do_reset();
        cnt_sel_i = 4'd1;
        run_one(32'h0000_0073, 10'h002, 3);
        n_cmp++;
        if (mis3 !== 1'b0 || errc3 !== 16'd0 || txn3 !== 16'd1 || cnt3 !== 16'd1) begin
            n_bad++;
            $display("FAIL lat3_match mis=%0b err=%0d txn=%0d cnt=%0d want 0 0 1 1",
                     mis3, errc3, txn3, cnt3);
        end
        do_reset();
        run_one(32'h0000_0073, 10'h002, 2);
        tick();
        n_cmp++;
        if (errc3 !== 16'd2 || txn3 !== 16'd1 || fec3 !== 4'd15) begin
            n_bad++;
            $display("FAIL lat3_early err=%0d txn=%0d fec=%0d want 2 1 15", errc3, txn3, fec3);
        end
    endtask

    initial begin
        cnt_sel_i = 4'd0;
        test_reset();
        test_match_and_errors();
        test_spurious();
        test_back_to_back();
        test_clear();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
